mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 152 +++++++++++++++
 tb/tb_mem_responder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the MAR/MDR interface.
// Accepts a read or write strobe in IDLE and waits WAIT_CYCLES states.
// It then accesses a 2**ADDR_W x 32 RAM and signals completion with a
// one-cycle mem_done pulse.
// Optional build macro MEM_BOUNDS_CHECK_EN adds the err port. With it,
// out-of-range addresses are rejected instead of wrapping.
module mem_responder #(
   parameter int unsigned ADDR_W      = 9,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        mem_done,
   output logic        busy
`ifdef MEM_BOUNDS_CHECK_EN
   ,
   output logic        err
`endif
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   logic [DATA_W-1:0] ram [DEPTH];

   logic [1:0]        state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [ADDR_W-1:0] idx_l, idx_nxt;
   logic [DATA_W-1:0] wdata_l, wdata_nxt;
   logic              wr_l, wr_nxt;
   logic              busy_nxt;
   logic              done_nxt;
   logic              ram_we_c;
   logic              rd_ld_c;
   logic              oob_c;

`ifdef MEM_BOUNDS_CHECK_EN
   logic              oob_l, oob_nxt;
   logic              err_nxt;
   assign oob_c = oob_l;
`else
   // Upper address bits are deliberately dropped: addresses wrap.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr[DATA_W-1:ADDR_W];
   assign oob_c = 1'b0;
`endif

   // Next-state, request latching and access control.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx_l;
      wdata_nxt = wdata_l;
      wr_nxt    = wr_l;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      ram_we_c  = 1'b0;
      rd_ld_c   = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      oob_nxt   = oob_l;
      err_nxt   = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (mem_read || mem_write) begin
               idx_nxt   = addr[ADDR_W-1:0];
               wdata_nxt = wdata;
               wr_nxt    = mem_write;
               busy_nxt  = 1'b1;
               cnt_nxt   = CNT_W'(WAIT_CYCLES);
`ifdef MEM_BOUNDS_CHECK_EN
               oob_nxt   = (addr[DATA_W-1:ADDR_W] != '0);
`endif
               state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
            end
         end
         ST_WAIT: begin
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt <= CNT_W'(1)) begin
               state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
            if (!oob_c) begin
               ram_we_c = wr_l;
               rd_ld_c  = !wr_l;
            end
`ifdef MEM_BOUNDS_CHECK_EN
            err_nxt = oob_l;
`endif
         end
         default: begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         idx_l    <= '0;
         wdata_l  <= '0;
         wr_l     <= 1'b0;
         busy     <= 1'b0;
         mem_done <= 1'b0;
         rdata    <= '0;
`ifdef MEM_BOUNDS_CHECK_EN
         oob_l    <= 1'b0;
         err      <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         idx_l    <= idx_nxt;
         wdata_l  <= wdata_nxt;
         wr_l     <= wr_nxt;
         busy     <= busy_nxt;
         mem_done <= done_nxt;
         if (rd_ld_c) begin
            rdata <= ram[idx_l];
         end
`ifdef MEM_BOUNDS_CHECK_EN
         oob_l    <= oob_nxt;
         err      <= err_nxt;
`endif
      end
   end

   // RAM write port; not gated by reset so a write on the ACCESS edge lands.
   always_ff @(posedge clock) begin
      if (ram_we_c) begin
         ram[idx_l] <= wdata_l;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder. Two instances (WAIT_CYCLES=2 and 0) share
// the request inputs. Each is checked against a per-instance memory and
// rdata model.
module tb_mem_responder;

   localparam int unsigned ADDR_W = 9;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;

   logic        clock;
   logic        reset;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata_o [2];
   logic        done_o  [2];
   logic        busy_o  [2];
`ifdef MEM_BOUNDS_CHECK_EN
   logic        err_o   [2];
`endif

   int checks;
   int failures;

   logic [31:0] mdl  [2][DEPTH];
   logic [31:0] rexp [2];

   mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) u_w2 (
      .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .wdata(wdata), .rdata(rdata_o[0]), .mem_done(done_o[0]),
      .busy(busy_o[0])
`ifdef MEM_BOUNDS_CHECK_EN
      , .err(err_o[0])
`endif
   );

   mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u_w0 (
      .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .wdata(wdata), .rdata(rdata_o[1]), .mem_done(done_o[1]),
      .busy(busy_o[1])
`ifdef MEM_BOUNDS_CHECK_EN
      , .err(err_o[1])
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One access: drive a strobe for one edge, then watch both instances for 8 cycles.
   task automatic do_op(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit poke, input string tag);
      logic [31:0] old_r [2];
      logic [31:0] exp_r;
      logic [ADDR_W-1:0] idx;
      bit oob;
      int lat, dc [2], np [2], bbad [2], rbad [2], ebad [2];
      idx = a[ADDR_W-1:0];
      oob = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      oob = (a[31:ADDR_W] != '0);
`endif
      for (int i = 0; i < 2; i++) begin
         old_r[i] = rexp[i];
         dc[i] = 0; np[i] = 0; bbad[i] = 0; rbad[i] = 0; ebad[i] = 0;
         if (!oob) begin
            if (wr) mdl[i][idx] = d;
            else    rexp[i] = mdl[i][idx];
         end
      end
      @(negedge clock);
      mem_read = rd; mem_write = wr; addr = a; wdata = d;
      @(posedge clock); #1;
      mem_read = 1'b0; mem_write = 1'b0; addr = $urandom; wdata = $urandom;
      for (int c = 1; c <= 8; c++) begin
         for (int i = 0; i < 2; i++) begin
            lat = (i == 0) ? 4 : 2;
            if (done_o[i]) begin
               np[i]++;
               if (dc[i] == 0) dc[i] = c;
            end
            if (busy_o[i] !== (c <= lat)) bbad[i]++;
            exp_r = (c < lat) ? old_r[i] : rexp[i];
            if (rdata_o[i] !== exp_r) rbad[i]++;
`ifdef MEM_BOUNDS_CHECK_EN
            if (err_o[i] !== ((c == lat) && oob)) ebad[i]++;
`endif
         end
         if (poke && c == 2) begin mem_read = 1'b1; addr = 32'h40; end
         if (poke && c == 3) begin mem_read = 1'b0; end
         @(posedge clock); #1;
      end
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_done_cycle_%0d", tag, i), 32'(dc[i]), (i == 0) ? 32'd4 : 32'd2);
         check($sformatf("%s_done_pulses_%0d", tag, i), 32'(np[i]), 32'd1);
         check($sformatf("%s_busy_window_%0d", tag, i), 32'(bbad[i]), 32'd0);
         check($sformatf("%s_rdata_timing_%0d", tag, i), 32'(rbad[i]), 32'd0);
         check($sformatf("%s_rdata_%0d", tag, i), rdata_o[i], rexp[i]);
`ifdef MEM_BOUNDS_CHECK_EN
         check($sformatf("%s_err_%0d", tag, i), 32'(ebad[i]), 32'd0);
`endif
      end
   endtask

   // Write to 0x8 with reset on the edge after acceptance. For WAIT=2 that
   // edge is in WAIT (aborted); for WAIT=0 it is the ACCESS edge (write lands).
   task automatic reset_mid_op();
      @(negedge clock);
      mem_write = 1'b1; addr = 32'h8; wdata = 32'hFFFF_FFFF;
      @(posedge clock); #1;
      mem_write = 1'b0; reset = 1'b1;
      @(posedge clock); #1;
      mdl[1][8] = 32'hFFFF_FFFF;
      for (int i = 0; i < 2; i++) begin
         rexp[i] = 32'h0;
         check($sformatf("rst_busy_%0d", i), 32'(busy_o[i]), 32'd0);
         check($sformatf("rst_done_%0d", i), 32'(done_o[i]), 32'd0);
         check($sformatf("rst_rdata_%0d", i), rdata_o[i], 32'h0);
      end
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clock); #1;
         for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_quiet_done_%0d", i), 32'(done_o[i]), 32'd0);
         end
      end
   endtask

   initial begin
      logic [31:0] a, d, hi;
      int op;
      checks = 0; failures = 0;
      reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
      rexp[0] = '0; rexp[1] = '0;
      repeat (3) @(posedge clock);
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("reset_rdata_%0d", i), rdata_o[i], 32'h0);
         check($sformatf("reset_done_%0d", i), 32'(done_o[i]), 32'd0);
         check($sformatf("reset_busy_%0d", i), 32'(busy_o[i]), 32'd0);
`ifdef MEM_BOUNDS_CHECK_EN
         check($sformatf("reset_err_%0d", i), 32'(err_o[i]), 32'd0);
`endif
      end
      reset = 1'b0;

      // Preload the low 64 words so every later read has a defined value.
      for (int k = 0; k < 64; k++) begin
         if (k == 3)      d = 32'h1234_5678;
         else if (k == 8) d = 32'h0;
         else             d = $urandom;
         do_op(1'b0, 1'b1, 32'(k), d, 1'b0, "preload");
      end

      do_op(1'b0, 1'b1, 32'h10, 32'hCAFE_F00D, 1'b0, "wr_10");
      do_op(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, "rd_10");
      do_op(1'b1, 1'b0, 32'h3, 32'h0, 1'b0, "rd_03");
      do_op(1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5, 1'b0, "both_20");
      do_op(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, "rd_20");
      do_op(1'b0, 1'b1, 32'h3C, 32'h0BAD_BEEF, 1'b1, "busy_ignore");
      reset_mid_op();
      do_op(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, "rd_08");
      do_op(1'b0, 1'b1, 32'h205, 32'h5EED_0205, 1'b0, "wr_205");
      do_op(1'b1, 1'b0, 32'h5, 32'h0, 1'b0, "rd_005");

      for (int k = 0; k < 40; k++) begin
         op = int'($urandom_range(0, 2));
         hi = ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_FE00) : 32'h0;
         a  = hi | 32'($urandom_range(0, 63));
         d  = $urandom;
         do_op(op != 1, op != 0, a, d, ($urandom_range(0, 3) == 0), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
